// File: rtl/multdiv_issuer_if.sv
// multdiv_issuer_if: bundles the request, response and multdiv launch-side
// signals of multdiv_issuer. The master modport is the environment side
// (pipeline plus multdiv). The slave modport is the issuer itself.
interface multdiv_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;

    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_exception;
    logic [4:0]  rsp_tag;
    logic        rsp_timeout;
    logic        busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        input  req_ready,
        input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        output md_result, md_exception, md_resultRDY,
        input  rsp_valid, rsp_result, rsp_exception, rsp_tag, rsp_timeout,
        output rsp_ready,
        input  busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        output req_ready,
        output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
        input  md_result, md_exception, md_resultRDY,
        output rsp_valid, rsp_result, rsp_exception, rsp_tag, rsp_timeout,
        input  rsp_ready,
        output busy
    );
endinterface

// File: rtl/multdiv_issuer.sv
// multdiv_issuer: sequences one multiply/divide request at a time into the
// multdiv unit. It latches the operands, pulses one ctrl line for a cycle,
// waits for resultRDY and then returns the result over a valid/ready response.
// Optional feature: define MULTDIV_TIMEOUT_EN to add a WAIT-state watchdog.
// When the watchdog fires after TIMEOUT_CYCLES, it answers with an exception.
module multdiv_issuer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    multdiv_issuer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_div;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        exc;
    logic        rdy_seen;
    logic        wait_expired;
    logic        tmo;

    // RDY only counts while waiting, so a stale RDY cannot complete a new op
    assign rdy_seen = (state == WAIT) && bus.md_resultRDY;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Watchdog counter: zero outside WAIT, counts completed WAIT cycles inside
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // RDY has priority, so expiry only matters when RDY is absent
    assign wait_expired = (state == WAIT) && !bus.md_resultRDY &&
                          (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Timeout flag is recorded with every completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo <= 1'b0;
        end else if (rdy_seen) begin
            tmo <= 1'b0;
        end else if (wait_expired) begin
            tmo <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign tmo          = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one request in flight, strictly IDLE->ISSUE->WAIT->RESP
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (bus.req_valid) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (rdy_seen || wait_expired) state_next = RESP;
            RESP:  if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control outputs decoded purely from registered state
    always_comb begin
        bus.req_ready    = (state == IDLE);
        bus.busy         = (state != IDLE);
        bus.md_ctrl_MULT = (state == ISSUE) && !op_div;
        bus.md_ctrl_DIV  = (state == ISSUE) && op_div;
        bus.rsp_valid    = (state == RESP);
    end

    // Request latch on accept, result capture on completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_div <= 1'b0;
            tag    <= '0;
            res    <= '0;
            exc    <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.req_valid) begin
                op_a   <= bus.req_a;
                op_b   <= bus.req_b;
                op_div <= bus.req_op;
                tag    <= bus.req_tag;
            end
            if (rdy_seen) begin
                res <= bus.md_result;
                exc <= bus.md_exception;
            end else if (wait_expired) begin
                res <= '0;
                exc <= 1'b1;
            end
        end
    end

    assign bus.md_operandA   = op_a;
    assign bus.md_operandB   = op_b;
    assign bus.rsp_result    = res;
    assign bus.rsp_exception = exc;
    assign bus.rsp_tag       = tag;
    assign bus.rsp_timeout   = tmo;

endmodule

// File: tb/tb_multdiv_issuer.sv
// tb_multdiv_issuer: directed bench for multdiv_issuer. The bench plays both
// the pipeline and the multdiv unit. A transaction-level model predicts the
// outputs, and a compare process checks them on every falling edge.
module tb_multdiv_issuer;

    localparam int TMO = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    multdiv_issuer_if bus();

    multdiv_issuer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // Transaction model: pending request record and pending response record
    int          cyc     = 0;
    int          m_acc   = 0;
    bit          m_req   = 1'b0;
    bit          m_rsp   = 1'b0;
    bit          m_op    = 1'b0;
    logic [31:0] m_a     = '0;
    logic [31:0] m_b     = '0;
    logic [4:0]  m_tag   = '0;
    logic [31:0] m_res   = '0;
    bit          m_exc   = 1'b0;
    bit          m_tmo   = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Model update: cyc numbers the cycle that follows each rising edge
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc   <= 0;
            m_acc <= 0;
            m_req <= 1'b0;
            m_rsp <= 1'b0;
            m_op  <= 1'b0;
            m_a   <= '0;
            m_b   <= '0;
            m_tag <= '0;
            m_res <= '0;
            m_exc <= 1'b0;
            m_tmo <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_rsp) begin
                if (bus.rsp_ready) m_rsp <= 1'b0;
            end else if (m_req) begin
                if (cyc > m_acc && bus.md_resultRDY) begin
                    m_req <= 1'b0;
                    m_rsp <= 1'b1;
                    m_res <= bus.md_result;
                    m_exc <= bus.md_exception;
                    m_tmo <= 1'b0;
                end
`ifdef MULTDIV_TIMEOUT_EN
                else if (cyc - m_acc == TMO) begin
                    m_req <= 1'b0;
                    m_rsp <= 1'b1;
                    m_res <= '0;
                    m_exc <= 1'b1;
                    m_tmo <= 1'b1;
                end
`endif
            end else if (bus.req_valid) begin
                m_req <= 1'b1;
                m_acc <= cyc + 1;
                m_op  <= bus.req_op;
                m_a   <= bus.req_a;
                m_b   <= bus.req_b;
                m_tag <= bus.req_tag;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    always @(negedge clock) begin
        checkOutput("cyc_req_ready", 32'(bus.req_ready), 32'(!m_req && !m_rsp));
        checkOutput("cyc_busy", 32'(bus.busy), 32'(m_req || m_rsp));
        checkOutput("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp));
        checkOutput("cyc_ctrl_mult", 32'(bus.md_ctrl_MULT), 32'(m_req && cyc == m_acc && !m_op));
        checkOutput("cyc_ctrl_div", 32'(bus.md_ctrl_DIV), 32'(m_req && cyc == m_acc && m_op));
        checkOutput("cyc_operand_a", bus.md_operandA, m_a);
        checkOutput("cyc_operand_b", bus.md_operandB, m_b);
        if (m_rsp) begin
            checkOutput("cyc_rsp_result", bus.rsp_result, m_res);
            checkOutput("cyc_rsp_exception", 32'(bus.rsp_exception), 32'(m_exc));
            checkOutput("cyc_rsp_tag", 32'(bus.rsp_tag), 32'(m_tag));
            checkOutput("cyc_rsp_timeout", 32'(bus.rsp_timeout), 32'(m_tmo));
        end
    end

    // Present one request from IDLE and step through the ISSUE cycle
    task automatic applyStimulus(input bit op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] tag);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        tick();
        bus.req_valid = 1'b0;
        checkOutput("issue_mult", 32'(bus.md_ctrl_MULT), op ? 32'd0 : 32'd1);
        checkOutput("issue_div", 32'(bus.md_ctrl_DIV), op ? 32'd1 : 32'd0);
        checkOutput("issue_operand_a", bus.md_operandA, a);
        tick();
        checkOutput("wait_ctrl", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'd0);
    endtask

    // Act as multdiv: raise RDY after some WAIT cycles, then check the response
    task automatic complete_op(input logic [31:0] result, input bit exc,
                               input logic [4:0] tag, input int delay);
        repeat (delay) tick();
        bus.md_resultRDY = 1'b1;
        bus.md_result    = result;
        bus.md_exception = exc;
        tick();
        bus.md_resultRDY = 1'b0;
        bus.md_result    = 32'hDEAD_BEEF;
        bus.md_exception = 1'b0;
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("rsp_result", bus.rsp_result, result);
        checkOutput("rsp_exception", 32'(bus.rsp_exception), 32'(exc));
        checkOutput("rsp_tag", 32'(bus.rsp_tag), 32'(tag));
        checkOutput("rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checkOutput("back_to_idle", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_op       = 1'b0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.req_tag      = '0;
        bus.md_result    = '0;
        bus.md_exception = 1'b0;
        bus.md_resultRDY = 1'b0;
        bus.rsp_ready    = 1'b0;

        // Reset values
        tick();
        tick();
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_operand_a", bus.md_operandA, 32'd0);
        checkOutput("reset_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        checkOutput("reset_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        reset_n = 1'b1;
        tick();

        // Mult 3x0, tag 5
        applyStimulus(1'b0, 32'd3, 32'd0, 5'd5);
        complete_op(32'd0, 1'b0, 5'd5, 2);
        handshake();

        // Div 7/0 reports the multdiv exception
        applyStimulus(1'b1, 32'd7, 32'd0, 5'd9);
        complete_op(32'd0, 1'b1, 5'd9, 1);
        handshake();

        // Div 100/7 with a stalled consumer and a request waiting behind it
        applyStimulus(1'b1, 32'd100, 32'd7, 5'd17);
        complete_op(32'd14, 1'b0, 5'd17, 4);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_a     = 32'd2;
        bus.req_b     = 32'd9;
        bus.req_tag   = 5'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("hold_rsp_result", bus.rsp_result, 32'd14);
            checkOutput("hold_rsp_tag", 32'(bus.rsp_tag), 32'd17);
            checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checkOutput("resp_no_accept_busy", 32'(bus.busy), 32'd0);
        checkOutput("resp_no_accept_ctrl", 32'(bus.md_ctrl_MULT), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        checkOutput("queued_mult_pulse", 32'(bus.md_ctrl_MULT), 32'd1);
        tick();
        complete_op(32'd18, 1'b0, 5'd3, 0);
        handshake();

        // Stale RDY during IDLE and ISSUE must not complete the request
        bus.md_resultRDY = 1'b1;
        bus.md_result    = 32'd999;
        tick();
        tick();
        checkOutput("stale_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("stale_idle_busy", 32'(bus.busy), 32'd0);
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_a     = 32'd4;
        bus.req_b     = 32'd5;
        bus.req_tag   = 5'd2;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.md_resultRDY = 1'b0;
        checkOutput("stale_issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        tick();
        checkOutput("stale_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        complete_op(32'd20, 1'b0, 5'd2, 0);
        handshake();

        // Reset three cycles into WAIT, then a late RDY arrives in IDLE
        applyStimulus(1'b1, 32'd50, 32'd5, 5'd11);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("rst_ctrl", 32'({bus.md_ctrl_MULT, bus.md_ctrl_DIV}), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_operand_a", bus.md_operandA, 32'd0);
        bus.md_resultRDY = 1'b1;
        bus.md_result    = 32'd10;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("late_rdy_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("late_rdy_busy", 32'(bus.busy), 32'd0);
        bus.md_resultRDY = 1'b0;
        applyStimulus(1'b0, 32'd6, 32'd7, 5'd12);
        complete_op(32'd42, 1'b0, 5'd12, 1);
        handshake();

`ifdef MULTDIV_TIMEOUT_EN
        // Watchdog: no RDY, response after exactly TMO WAIT cycles
        applyStimulus(1'b0, 32'd1, 32'd1, 5'd20);
        repeat (TMO - 1) tick();
        checkOutput("tmo_early_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        checkOutput("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("tmo_rsp_timeout", 32'(bus.rsp_timeout), 32'd1);
        checkOutput("tmo_rsp_exception", 32'(bus.rsp_exception), 32'd1);
        checkOutput("tmo_rsp_result", bus.rsp_result, 32'd0);
        checkOutput("tmo_rsp_tag", 32'(bus.rsp_tag), 32'd20);
        handshake();
`endif

        tick();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
